// File: rtl/irq_dispatch_arbiter.sv
// Interrupt dispatcher: picks the highest-priority eligible requester (round-robin on ties),
// presents it to the CPU, and tracks it through acknowledge and end-of-interrupt.
module irq_dispatch_arbiter #(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3,
   parameter int TIMEOUT = 16
) (
   input  logic                       pclk,
   input  logic                       rst,
   input  logic [NUM_SRC-1:0]         src_req,
   input  logic [NUM_SRC*PRIO_W-1:0]  src_prio,
   input  logic [NUM_SRC-1:0]         src_mask,
   input  logic                       cpu_ack,
   input  logic                       cpu_eoi,
   input  logic [$clog2(NUM_SRC)-1:0] eoi_id,
   output logic                       cpu_irq,
   output logic [$clog2(NUM_SRC)-1:0] cpu_vec,
   output logic [NUM_SRC-1:0]         src_grant,
   output logic                       busy,
   output logic                       timeout_err,
   output logic                       eoi_err
);

   // state   | meaning
   // IDLE    | arbitrating every cycle among eligible requesters
   // PRESENT | cpu_irq asserted, waiting for cpu_ack, withdrawal or timeout
   // SERVICE | interrupt accepted, waiting for matching cpu_eoi
   localparam int ID_W  = $clog2(NUM_SRC);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

   state_t             state, state_nxt;
   logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [ID_W-1:0]    vec_nxt, winner, idx;
   logic [ID_W:0]      sum;
   logic               win_valid, tmo_hit, withdrawn;
   logic [PRIO_W-1:0]  best;
   logic [PRIO_W-1:0]  prio [NUM_SRC];
   logic [NUM_SRC-1:0] eligible, grant_nxt;
   logic               irq_nxt, busy_nxt, tmo_nxt, eoi_err_nxt;

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         prio[i] = src_prio[i*PRIO_W +: PRIO_W];
      end
   end

   // Scanning in round-robin order with a strict compare keeps the first tied source found.
   always_comb begin
      eligible  = src_req & ~src_mask;
      win_valid = 1'b0;
      winner    = '0;
      best      = '1;
      sum       = '0;
      idx       = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_SRC)) begin
            sum = sum - (ID_W+1)'(NUM_SRC);
         end
         idx = sum[ID_W-1:0];
         if (eligible[idx] && (!win_valid || prio[idx] < best)) begin
            win_valid = 1'b1;
            winner    = idx;
            best      = prio[idx];
         end
      end
   end

   always_comb begin
      tmo_hit   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
      withdrawn = !src_req[cpu_vec];
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= ID_W'(NUM_SRC - 1);
         cnt         <= '0;
         cpu_irq     <= 1'b0;
         cpu_vec     <= '0;
         src_grant   <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         eoi_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         cnt         <= cnt_nxt;
         cpu_irq     <= irq_nxt;
         cpu_vec     <= vec_nxt;
         src_grant   <= grant_nxt;
         busy        <= busy_nxt;
         timeout_err <= tmo_nxt;
         eoi_err     <= eoi_err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (win_valid) state_nxt = PRESENT;
         end
         PRESENT: begin
            if (cpu_ack)        state_nxt = SERVICE;
            else if (withdrawn) state_nxt = IDLE;
            else if (tmo_hit)   state_nxt = IDLE;
         end
         SERVICE: begin
            if (cpu_eoi && eoi_id == cpu_vec) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      irq_nxt     = (state_nxt == PRESENT);
      busy_nxt    = (state_nxt != IDLE);
      vec_nxt     = cpu_vec;
      grant_nxt   = '0;
      tmo_nxt     = 1'b0;
      rr_ptr_nxt  = rr_ptr;
      cnt_nxt     = cnt;
      eoi_err_nxt = cpu_eoi && !(state == SERVICE && eoi_id == cpu_vec);
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (win_valid) vec_nxt = winner;
         end
         PRESENT: begin
            if (cpu_ack) begin
               grant_nxt[cpu_vec] = 1'b1;
               rr_ptr_nxt         = cpu_vec;
            end else if (!withdrawn) begin
               if (tmo_hit) begin
                  tmo_nxt    = 1'b1;
                  rr_ptr_nxt = cpu_vec;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_irq_dispatch_arbiter.sv
// Self-checking bench for irq_dispatch_arbiter: a per-cycle reference model compared on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_irq_dispatch_arbiter;
   localparam int NUM_SRC = 8;
   localparam int PRIO_W  = 3;
   localparam int TIMEOUT = 16;
   localparam int ID_W    = $clog2(NUM_SRC);

   logic                      pclk = 1'b0;
   logic                      rst = 1'b0;
   logic [NUM_SRC-1:0]        src_req = '0;
   logic [NUM_SRC*PRIO_W-1:0] src_prio = '1;
   logic [NUM_SRC-1:0]        src_mask = '0;
   logic                      cpu_ack = 1'b0;
   logic                      cpu_eoi = 1'b0;
   logic [ID_W-1:0]           eoi_id = '0;
   logic                      cpu_irq;
   logic [ID_W-1:0]           cpu_vec;
   logic [NUM_SRC-1:0]        src_grant;
   logic                      busy, timeout_err, eoi_err;

   int n_checks = 0;
   int n_err = 0;
   bit started = 0;

   irq_dispatch_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .rst(rst), .src_req(src_req), .src_prio(src_prio), .src_mask(src_mask),
      .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .eoi_id(eoi_id), .cpu_irq(cpu_irq),
      .cpu_vec(cpu_vec), .src_grant(src_grant), .busy(busy), .timeout_err(timeout_err),
      .eoi_err(eoi_err));

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 presented, 2 in service.
   int m_mode = 0, m_vec = 0, m_rr = NUM_SRC - 1, m_age = 0;
   int e_grant = 0;
   bit e_tmo = 0, e_eoierr = 0;

   function automatic int prio_of(input int i);
      return int'((src_prio >> (i * PRIO_W)) & ((1 << PRIO_W) - 1));
   endfunction

   // Best priority level first, then the first requester at that level in rotation order.
   function automatic int pick();
      for (int p = 0; p < (1 << PRIO_W); p++) begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            int i = (m_rr + k) % NUM_SRC;
            if (src_req[i] && !src_mask[i] && prio_of(i) == p) return i;
         end
      end
      return -1;
   endfunction

   always @(posedge pclk or posedge rst) begin
      if (rst) begin
         started = 1;
         m_mode = 0; m_vec = 0; m_rr = NUM_SRC - 1; m_age = 0;
         e_grant = 0; e_tmo = 0; e_eoierr = 0;
      end else begin
         int w;
         e_grant = 0; e_tmo = 0;
         e_eoierr = cpu_eoi && !(m_mode == 2 && int'(eoi_id) == m_vec);
         case (m_mode)
            0: begin
               w = pick();
               if (w >= 0) begin m_mode = 1; m_vec = w; m_age = 0; end
            end
            1: begin
               if (cpu_ack) begin
                  e_grant = 1 << m_vec; m_rr = m_vec; m_mode = 2;
               end else if (!src_req[m_vec]) begin
                  m_mode = 0;
               end else begin
                  m_age++;
                  if (TIMEOUT != 0 && m_age == TIMEOUT) begin
                     e_tmo = 1; m_rr = m_vec; m_mode = 0;
                  end
               end
            end
            default: if (cpu_eoi && int'(eoi_id) == m_vec) m_mode = 0;
         endcase
      end
   end

   always @(negedge pclk) begin
      if (started && !rst) begin
         chk("m_irq",   32'(cpu_irq),     32'(m_mode == 1));
         chk("m_busy",  32'(busy),        32'(m_mode != 0));
         chk("m_vec",   32'(cpu_vec),     32'(m_vec));
         chk("m_grant", 32'(src_grant),   32'(e_grant));
         chk("m_tmo",   32'(timeout_err), 32'(e_tmo));
         chk("m_eoi",   32'(eoi_err),     32'(e_eoierr));
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_prio(input int i, input int p);
      src_prio[i*PRIO_W +: PRIO_W] = PRIO_W'(p);
   endtask

   task automatic wait_irq();
      int n = 0;
      while (cpu_irq !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("wait_irq_bound", 32'(n < 40), 32'd1);
   endtask

   task automatic do_ack();
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
   endtask

   task automatic do_eoi(input int id);
      cpu_eoi = 1'b1; eoi_id = ID_W'(id); tick(); cpu_eoi = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int cnt;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      #2 rst = 1'b1;
      tick(); tick();
      chk("rst_irq", 32'(cpu_irq), 0);
      chk("rst_vec", 32'(cpu_vec), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(src_grant), 0);
      rst = 1'b0;

      // Priority winner, grant, bad and good EOI
      src_req = 8'h24; set_prio(2, 3); set_prio(5, 1);
      tick();
      chk("t1_irq", 32'(cpu_irq), 1);
      chk("t1_vec", 32'(cpu_vec), 5);
      do_ack();
      chk("t1_grant", 32'(src_grant), 32'h20);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_irq_drop", 32'(cpu_irq), 0);
      src_req = '0;
      tick();
      chk("t1_grant_pulse", 32'(src_grant), 0);
      do_eoi(3);
      chk("t1_eoi_err", 32'(eoi_err), 1);
      chk("t1_still_busy", 32'(busy), 1);
      chk("t1_svc_vec", 32'(cpu_vec), 5);
      do_eoi(5);
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_eoi_ok", 32'(eoi_err), 0);

      // Round-robin among equal priorities
      for (int i = 0; i < NUM_SRC; i++) set_prio(i, 2);
      src_req = 8'h0F;
      for (int r = 0; r < 5; r++) begin
         wait_irq();
         chk("t2_order", 32'(cpu_vec), 32'(exp_order[r]));
         do_ack();
         chk("t2_grant", 32'(src_grant), 32'(1 << exp_order[r]));
         if (r == 4) src_req = '0;
         do_eoi(exp_order[r]);
      end

      // Timeout after 16 presented cycles, then re-presentation
      src_req = 8'h01; set_prio(0, 0);
      tick();
      chk("t3_irq", 32'(cpu_irq), 1);
      cnt = 0;
      while (cpu_irq === 1'b1 && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("t3_cycles", 32'(cnt), 16);
      chk("t3_tmo", 32'(timeout_err), 1);
      chk("t3_busy", 32'(busy), 0);
      tick();
      chk("t3_repres", 32'(cpu_irq), 1);
      chk("t3_repres_vec", 32'(cpu_vec), 0);
      chk("t3_tmo_pulse", 32'(timeout_err), 0);

      // Withdrawn request
      src_req = 8'h00;
      tick();
      chk("t4_irq", 32'(cpu_irq), 0);
      chk("t4_grant", 32'(src_grant), 0);
      src_req = 8'h10;
      tick();
      chk("t4_vec", 32'(cpu_vec), 4);
      src_req = 8'h00;
      tick();
      chk("t4_drop_irq", 32'(cpu_irq), 0);
      chk("t4_drop_busy", 32'(busy), 0);

      // EOI outside SERVICE, ack outside PRESENT
      cpu_ack = 1'b1;
      do_eoi(0);
      cpu_ack = 1'b0;
      chk("t5_eoi_idle", 32'(eoi_err), 1);
      chk("t5_ack_idle", 32'(src_grant), 0);

      // Ack on the final timeout cycle wins
      src_req = 8'h02;
      tick();
      chk("t6_vec", 32'(cpu_vec), 1);
      repeat (15) tick();
      chk("t6_irq_held", 32'(cpu_irq), 1);
      do_ack();
      chk("t6_grant", 32'(src_grant), 32'h02);
      chk("t6_no_tmo", 32'(timeout_err), 0);
      src_req = '0;
      do_eoi(1);

      // Ack together with withdrawal counts as ack
      src_req = 8'h04;
      tick();
      src_req = 8'h00;
      do_ack();
      chk("t7_grant", 32'(src_grant), 32'h04);
      do_eoi(2);

      // No re-arbitration in PRESENT, no nesting, back-to-back service
      set_prio(3, 5); set_prio(0, 0);
      src_req = 8'h08;
      tick();
      chk("t8_vec", 32'(cpu_vec), 3);
      src_req = 8'h09; src_mask = 8'h08;
      tick(); tick();
      chk("t8_held_vec", 32'(cpu_vec), 3);
      chk("t8_held_irq", 32'(cpu_irq), 1);
      do_ack();
      chk("t8_grant", 32'(src_grant), 32'h08);
      src_mask = '0;
      tick(); tick();
      chk("t8_no_nest", 32'(cpu_irq), 0);
      do_eoi(3);
      chk("t8_idle", 32'(busy), 0);
      tick();
      chk("t8_b2b_irq", 32'(cpu_irq), 1);
      chk("t8_b2b_vec", 32'(cpu_vec), 0);
      do_ack();

      // Asynchronous reset while in SERVICE
      #3 rst = 1'b1;
      #1;
      chk("t9_irq", 32'(cpu_irq), 0);
      chk("t9_vec", 32'(cpu_vec), 0);
      chk("t9_busy", 32'(busy), 0);
      chk("t9_grant", 32'(src_grant), 0);
      chk("t9_tmo", 32'(timeout_err), 0);
      chk("t9_eoi", 32'(eoi_err), 0);
      src_req = '0;
      tick();
      rst = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
